multicycle_ctrl: RTL

- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, memory port, instruction register, PC and the register file write port (regWrite) through the FETCH, DECODE, EXECUTE, MEM and WB steps.
- Consumes the latched instruction and handshakes with a variable-latency memory.
- Produces one-hot-in-time strobes and Moore datapath selects, plus a retired-instruction counter and trap/halt status.

---
 rtl/ctrl_pkg.sv | 61 ++++++
 rtl/mem_wait_timer.sv | 36 +++
 rtl/multicycle_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: state encoding,
// major opcodes and the datapath select encodings.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_AUIPC  = 4'd4,
      S_ADDR   = 4'd5,
      S_MEM_RD = 4'd6,
      S_MEM_WR = 4'd7,
      S_WB_ALU = 4'd8,
      S_WB_MEM = 4'd9,
      S_LUI    = 4'd10,
      S_BRANCH = 4'd11,
      S_JAL    = 4'd12,
      S_JALR   = 4'd13,
      S_HALT   = 4'd14,
      S_TRAP   = 4'd15
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_RS1   = 2'd1;
   localparam logic [1:0] SRC_A_OLDPC = 2'd2;

   localparam logic [1:0] SRC_B_RS2  = 2'd0;
   localparam logic [1:0] SRC_B_FOUR = 2'd1;
   localparam logic [1:0] SRC_B_IMM  = 2'd2;

   localparam logic [1:0] ALUOP_ADD   = 2'd0;
   localparam logic [1:0] ALUOP_BR    = 2'd1;
   localparam logic [1:0] ALUOP_FUNCT = 2'd2;

   localparam logic [1:0] WB_ALUOUT   = 2'd0;
   localparam logic [1:0] WB_MEM_DATA = 2'd1;
   localparam logic [1:0] WB_LINK     = 2'd2;
   localparam logic [1:0] WB_IMM      = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JALR   = 2'd2;

   // States that sit on the memory handshake and are covered by the timeout.
   function automatic logic is_mem_wait(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready and flags the cycle in
// which the count would reach MEM_TIMEOUT (0 disables the flag).
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [W-1:0] LAST = W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Fires on the wait cycle whose increment would hit the limit.
   assign expired_o = (MEM_TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and write-back, counts retired instructions.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst,
   input  logic             mem_ready,
   input  logic             br_taken,
   output logic             pc_write,
   output logic             ir_write,
   output logic             old_pc_write,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       wb_sel,
   output logic [1:0]       pc_src,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instret,
   output logic             trap,
   output logic             halted
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] instret_q;
   logic             waiting, tmo_expired, retire;
   logic             unused_inst;

   assign unused_inst = ^{inst[31:7]};

   assign waiting = rst && is_mem_wait(state_q) && !mem_ready;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (!waiting),
      .en_i     (waiting),
      .expired_o(tmo_expired)
   );

   always_comb begin
      state_d      = state_q;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      old_pc_write = 1'b0;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      iord         = 1'b0;
      alu_src_a    = SRC_A_PC;
      alu_src_b    = SRC_B_RS2;
      alu_op       = ALUOP_ADD;
      wb_sel       = WB_ALUOUT;
      pc_src       = PCSRC_ALU;
      if (!rst) begin
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRC_B_FOUR;
               if (mem_ready) begin
                  ir_write     = 1'b1;
                  pc_write     = 1'b1;
                  old_pc_write = 1'b1;
                  state_d      = S_DECODE;
               end else if (tmo_expired) begin
                  state_d = S_TRAP;
               end
            end
            S_DECODE: begin
               // Speculatively form the branch/JAL target into ALUOut.
               alu_src_a = SRC_A_OLDPC;
               alu_src_b = SRC_B_IMM;
               case (inst[6:0])
                  OP_R:               state_d = S_EXEC_R;
                  OP_I:               state_d = S_EXEC_I;
                  OP_LOAD, OP_STORE:  state_d = S_ADDR;
                  OP_BRANCH:          state_d = S_BRANCH;
                  OP_JAL:             state_d = S_JAL;
                  OP_JALR:            state_d = S_JALR;
                  OP_LUI:             state_d = S_LUI;
                  OP_AUIPC:           state_d = S_AUIPC;
                  OP_SYSTEM:          state_d = S_HALT;
                  default:            state_d = S_TRAP;
               endcase
            end
            S_EXEC_R: begin
               alu_src_a = SRC_A_RS1;
               alu_op    = ALUOP_FUNCT;
               state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               alu_op    = ALUOP_FUNCT;
               state_d   = S_WB_ALU;
            end
            S_AUIPC: begin
               alu_src_a = SRC_A_OLDPC;
               alu_src_b = SRC_B_IMM;
               state_d   = S_WB_ALU;
            end
            S_ADDR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               state_d   = inst[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               mem_read = 1'b1;
               iord     = 1'b1;
               if (mem_ready)
                  state_d = S_WB_MEM;
               else if (tmo_expired)
                  state_d = S_TRAP;
            end
            S_MEM_WR: begin
               mem_write = 1'b1;
               iord      = 1'b1;
               if (mem_ready)
                  state_d = S_FETCH;
               else if (tmo_expired)
                  state_d = S_TRAP;
            end
            S_WB_ALU: begin
               reg_write = 1'b1;
               state_d   = S_FETCH;
            end
            S_WB_MEM: begin
               reg_write = 1'b1;
               wb_sel    = WB_MEM_DATA;
               state_d   = S_FETCH;
            end
            S_LUI: begin
               reg_write = 1'b1;
               wb_sel    = WB_IMM;
               state_d   = S_FETCH;
            end
            S_BRANCH: begin
               alu_src_a = SRC_A_RS1;
               alu_op    = ALUOP_BR;
               pc_src    = PCSRC_ALUOUT;
               pc_write  = br_taken;
               state_d   = S_FETCH;
            end
            S_JAL: begin
               reg_write = 1'b1;
               wb_sel    = WB_LINK;
               pc_src    = PCSRC_ALUOUT;
               pc_write  = 1'b1;
               state_d   = S_FETCH;
            end
            S_JALR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               reg_write = 1'b1;
               wb_sel    = WB_LINK;
               pc_src    = PCSRC_JALR;
               pc_write  = 1'b1;
               state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
         endcase
      end
   end

   // Only terminal instruction states ever fall back into FETCH.
   assign retire = rst && (state_d == S_FETCH) && (state_q != S_FETCH);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire)
            instret_q <= instret_q + 1'b1;
      end
   end

   assign state   = state_q;
   assign instret = instret_q;
   assign trap    = (state_q == S_TRAP);
   assign halted  = (state_q == S_HALT);

endmodule
